// File: rtl/wb_commit.sv
// wb_commit: writeback stage that commits instructions, raises exception/ERTN flushes and counts retirements
module wb_commit #(
    parameter logic [5:0] ECODE_INT = 6'h00
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ms_to_ws_valid,
    input  logic [198:0] ms_to_ws_bus,
    output logic         ws_allowin,
    input  logic         has_int,
    input  logic [31:0]  csr_rvalue,
    input  logic [31:0]  ex_entry,
    input  logic [31:0]  ertn_entry,
    output logic         csr_re,
    output logic [13:0]  csr_num,
    output logic         csr_we,
    output logic [31:0]  csr_wmask,
    output logic [31:0]  csr_wvalue,
    output logic         wb_ex,
    output logic         ertn_flush,
    output logic [31:0]  wb_csr_pc,
    output logic [31:0]  wb_vaddr,
    output logic [5:0]   wb_ecode,
    output logic [8:0]   wb_esubcode,
    output logic         rf_we,
    output logic [4:0]   rf_waddr,
    output logic [31:0]  rf_wdata,
    output logic         ws_flush,
    output logic [31:0]  ws_flush_pc,
    output logic [31:0]  retire_cnt
);
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
    } ws_bus_t;

    ws_bus_t ws_bus;
    logic    ws_valid, ws_ready_go, take_int, take_ex;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;
    assign take_int    = ws_valid && has_int;
    assign take_ex     = ws_valid && (ws_bus.ex || has_int);

    assign wb_ex       = take_ex;
    assign wb_ecode    = take_int ? ECODE_INT : ws_bus.ecode;
    assign wb_esubcode = take_int ? 9'd0 : ws_bus.esubcode;
    assign wb_csr_pc   = ws_bus.pc;
    assign wb_vaddr    = ws_bus.vaddr;
    assign ertn_flush  = ws_valid && ws_bus.ertn && !take_ex;

    assign csr_we      = ws_valid && ws_bus.csr_we && !take_ex;
    assign csr_re      = ws_valid && ws_bus.csr_re;
    assign csr_num     = ws_bus.csr_num;
    assign csr_wmask   = ws_bus.wmask;
    assign csr_wvalue  = ws_bus.wvalue;

    assign rf_we       = ws_valid && ws_bus.gr_we && !take_ex;
    assign rf_waddr    = ws_bus.dest;
    assign rf_wdata    = ws_bus.csr_re ? csr_rvalue : ws_bus.result;

    assign ws_flush    = wb_ex || ertn_flush;
    assign ws_flush_pc = wb_ex ? ex_entry : ertn_entry;

    // A flushing commit drops whatever MEM offers in the same cycle, leaving one bubble
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid   <= 1'b0;
            ws_bus     <= '0;
            retire_cnt <= '0;
        end else begin
            if (ws_flush)
                ws_valid <= 1'b0;
            else if (ws_allowin)
                ws_valid <= ms_to_ws_valid;
            if (ws_allowin && ms_to_ws_valid && !ws_flush)
                ws_bus <= ms_to_ws_bus;
            if (ws_valid && !take_ex)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: directed and randomized checks of wb_commit against a commit-level reference model
module tb_wb_commit;
    localparam logic [5:0] ECI = 6'h2A;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] vaddr;
    } ins_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ms_to_ws_valid;
    logic [198:0] ms_to_ws_bus;
    logic         ws_allowin;
    logic         has_int;
    logic [31:0]  csr_rvalue, ex_entry, ertn_entry;
    logic         csr_re, csr_we, wb_ex, ertn_flush, rf_we, ws_flush;
    logic [13:0]  csr_num;
    logic [31:0]  csr_wmask, csr_wvalue, wb_csr_pc, wb_vaddr, rf_wdata, ws_flush_pc, retire_cnt;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [4:0]   rf_waddr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt;

    wb_commit #(.ECODE_INT(ECI)) dut (
        .clk(clk), .resetn(resetn),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ws_allowin(ws_allowin),
        .has_int(has_int), .csr_rvalue(csr_rvalue), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .csr_re(csr_re), .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input ins_t i);
        ms_to_ws_bus = i;
        ms_to_ws_valid = 1'b1;
        tick();
        ms_to_ws_valid = 1'b0;
    endtask

    function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
        ins_t i = '0;
        i.pc = pc;
        i.gr_we = 1'b1;
        i.dest = d;
        i.result = r;
        return i;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++; if (ws_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", ws_allowin); end
        checks++; if ({wb_ex, ertn_flush, csr_we, csr_re, rf_we, ws_flush} !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", {wb_ex, ertn_flush, csr_we, csr_re, rf_we, ws_flush}); end
        checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h exp 0", retire_cnt); end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        exp_cnt = 0;
    endtask

    task automatic test_alu();
        issue(alu(32'h1c000000, 5'd5, 32'h1234));
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_rf_we got %b exp 1", rf_we); end
        checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %h exp 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin errors++; $display("FAIL alu_wdata got %h exp 1234", rf_wdata); end
        checks++; if (ws_flush !== 1'b0) begin errors++; $display("FAIL alu_flush got %b exp 0", ws_flush); end
        tick();
        exp_cnt++;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL alu_cnt got %h exp %h", retire_cnt, exp_cnt); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_idle_rf_we got %b exp 0", rf_we); end
    endtask

    task automatic test_csrrd();
        ins_t i = alu(32'h1c000004, 5'd3, 32'h5555);
        i.csr_re = 1'b1;
        i.csr_num = 14'h6;
        csr_rvalue = 32'hABCD;
        issue(i);
        checks++; if (rf_wdata !== 32'hABCD) begin errors++; $display("FAIL csrrd_wdata got %h exp abcd", rf_wdata); end
        checks++; if ({csr_re, csr_we} !== 2'b10) begin errors++; $display("FAIL csrrd_strobes got %b exp 10", {csr_re, csr_we}); end
        checks++; if (csr_num !== 14'h6) begin errors++; $display("FAIL csrrd_num got %h exp 6", csr_num); end
        tick();
        exp_cnt++;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL csrrd_cnt got %h exp %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_exception();
        ins_t i = alu(32'h1c000008, 5'd9, 32'h77);
        i.csr_we = 1'b1;
        i.ex = 1'b1;
        i.ecode = 6'h9;
        i.esubcode = 9'h3;
        i.vaddr = 32'h1001;
        ex_entry = 32'h1c008000;
        ertn_entry = 32'h1c00dead;
        issue(i);
        ms_to_ws_bus = alu(32'h1c00000c, 5'd7, 32'h99);
        ms_to_ws_valid = 1'b1;
        #1;
        checks++; if (wb_ex !== 1'b1) begin errors++; $display("FAIL ex_wb_ex got %b exp 1", wb_ex); end
        checks++; if ({wb_ecode, wb_esubcode} !== {6'h9, 9'h3}) begin errors++; $display("FAIL ex_codes got %h/%h exp 09/003", wb_ecode, wb_esubcode); end
        checks++; if ({wb_csr_pc, wb_vaddr} !== {32'h1c000008, 32'h1001}) begin errors++; $display("FAIL ex_pc_vaddr got %h/%h exp 1c000008/00001001", wb_csr_pc, wb_vaddr); end
        checks++; if ({ws_flush, ws_flush_pc} !== {1'b1, 32'h1c008000}) begin errors++; $display("FAIL ex_flush got %b/%h exp 1/1c008000", ws_flush, ws_flush_pc); end
        checks++; if ({rf_we, csr_we, ertn_flush} !== 3'b000) begin errors++; $display("FAIL ex_suppress got %b exp 000", {rf_we, csr_we, ertn_flush}); end
        tick();
        ms_to_ws_valid = 1'b0;
        checks++; if ({rf_we, ws_flush} !== 2'b00) begin errors++; $display("FAIL ex_drop got %b exp 00", {rf_we, ws_flush}); end
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL ex_cnt got %h exp %h", retire_cnt, exp_cnt); end
        tick();
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL ex_bubble_cnt got %h exp %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_interrupt();
        ins_t i = alu(32'h1c000010, 5'd4, 32'h1);
        i.csr_we = 1'b1;
        i.csr_num = 14'h4;
        i.ecode = 6'h5;
        i.esubcode = 9'h1;
        has_int = 1'b1;
        ex_entry = 32'h1c00c000;
        issue(i);
        checks++; if ({wb_ex, wb_ecode, wb_esubcode} !== {1'b1, ECI, 9'h0}) begin errors++; $display("FAIL int_codes got %b/%h/%h exp 1/%h/000", wb_ex, wb_ecode, wb_esubcode, ECI); end
        checks++; if ({csr_we, rf_we} !== 2'b00) begin errors++; $display("FAIL int_suppress got %b exp 00", {csr_we, rf_we}); end
        checks++; if (ws_flush_pc !== 32'h1c00c000) begin errors++; $display("FAIL int_flush_pc got %h exp 1c00c000", ws_flush_pc); end
        tick();
        has_int = 1'b0;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL int_cnt got %h exp %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_ertn();
        ins_t i = '0;
        i.pc = 32'h1c000014;
        i.ertn = 1'b1;
        ertn_entry = 32'h1c000040;
        ex_entry = 32'h1c008000;
        issue(i);
        checks++; if ({ertn_flush, wb_ex, ws_flush} !== 3'b101) begin errors++; $display("FAIL ertn_strobes got %b exp 101", {ertn_flush, wb_ex, ws_flush}); end
        checks++; if (ws_flush_pc !== 32'h1c000040) begin errors++; $display("FAIL ertn_pc got %h exp 1c000040", ws_flush_pc); end
        tick();
        exp_cnt++;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL ertn_cnt got %h exp %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        ins_t i = alu(32'h1c000018, 5'd2, 32'h42);
        i.csr_re = 1'b1;
        i.ertn = 1'b1;
        issue(i);
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({wb_ex, ertn_flush, csr_we, csr_re, rf_we, ws_flush} !== 6'b0) begin errors++; $display("FAIL rstmid_strobes got %b exp 000000", {wb_ex, ertn_flush, csr_we, csr_re, rf_we, ws_flush}); end
        checks++; if ({ws_allowin, retire_cnt} !== {1'b1, 32'h0}) begin errors++; $display("FAIL rstmid_state got %b/%h exp 1/0", ws_allowin, retire_cnt); end
        @(negedge clk);
        resetn = 1'b1;
        exp_cnt = 0;
        issue(alu(32'h1c00001c, 5'd8, 32'h88));
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'h88}) begin errors++; $display("FAIL rstmid_resume got %b/%h/%h exp 1/08/88", rf_we, rf_waddr, rf_wdata); end
        tick();
        exp_cnt++;
        checks++; if (retire_cnt !== exp_cnt) begin errors++; $display("FAIL rstmid_cnt got %h exp %h", retire_cnt, exp_cnt); end
    endtask

    task automatic test_wrap();
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        issue(alu(32'h1c000020, 5'd1, 32'h1));
        tick();
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL wrap_cnt got %h exp 0", retire_cnt); end
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        i.pc = $urandom;
        i.gr_we = 1'($urandom_range(1));
        i.dest = 5'($urandom);
        i.result = $urandom;
        i.csr_re = ($urandom_range(3) == 0);
        i.csr_we = ($urandom_range(3) == 0);
        i.csr_num = 14'($urandom);
        i.wmask = $urandom;
        i.wvalue = $urandom;
        i.ertn = ($urandom_range(7) == 0);
        i.ex = ($urandom_range(7) == 0);
        i.ecode = 6'($urandom);
        i.esubcode = 9'($urandom);
        i.vaddr = $urandom;
        return i;
    endfunction

    // Model: one held instruction; each cycle it either traps, returns (ERTN) or retires normally
    task automatic test_random();
        logic   mv;
        ins_t   mi, ni;
        logic   v, trap, eret, ok;
        logic [31:0] mcnt;
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        mv = 1'b0;
        mi = '0;
        mcnt = 0;
        for (int n = 0; n < 400; n++) begin
            ni = rnd_ins();
            v = ($urandom_range(3) != 0);
            has_int = ($urandom_range(15) == 0);
            csr_rvalue = $urandom;
            ex_entry = $urandom;
            ertn_entry = $urandom;
            ms_to_ws_bus = ni;
            ms_to_ws_valid = v;
            #1;
            trap = mv && (mi.ex || has_int);
            eret = mv && mi.ertn && !trap;
            ok = mv && !trap;
            checks++; if ({wb_ex, ertn_flush, ws_flush} !== {trap, eret, trap || eret}) begin errors++; $display("FAIL rnd_flow[%0d] got %b exp %b", n, {wb_ex, ertn_flush, ws_flush}, {trap, eret, trap || eret}); end
            if (trap || eret) begin
                checks++; if (ws_flush_pc !== (trap ? ex_entry : ertn_entry)) begin errors++; $display("FAIL rnd_flush_pc[%0d] got %h exp %h", n, ws_flush_pc, trap ? ex_entry : ertn_entry); end
            end
            if (trap) begin
                checks++; if ({wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr} !== {has_int ? ECI : mi.ecode, has_int ? 9'h0 : mi.esubcode, mi.pc, mi.vaddr}) begin errors++; $display("FAIL rnd_trap[%0d] got %h/%h/%h/%h exp %h/%h/%h/%h", n, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, has_int ? ECI : mi.ecode, has_int ? 9'h0 : mi.esubcode, mi.pc, mi.vaddr); end
            end
            checks++; if ({csr_re, csr_we, rf_we} !== {mv && mi.csr_re, ok && mi.csr_we, ok && mi.gr_we}) begin errors++; $display("FAIL rnd_strobes[%0d] got %b exp %b", n, {csr_re, csr_we, rf_we}, {mv && mi.csr_re, ok && mi.csr_we, ok && mi.gr_we}); end
            if (mv) begin
                checks++; if ({csr_num, csr_wmask, csr_wvalue} !== {mi.csr_num, mi.wmask, mi.wvalue}) begin errors++; $display("FAIL rnd_csr[%0d] got %h/%h/%h exp %h/%h/%h", n, csr_num, csr_wmask, csr_wvalue, mi.csr_num, mi.wmask, mi.wvalue); end
                checks++; if ({rf_waddr, rf_wdata} !== {mi.dest, mi.csr_re ? csr_rvalue : mi.result}) begin errors++; $display("FAIL rnd_rf[%0d] got %h/%h exp %h/%h", n, rf_waddr, rf_wdata, mi.dest, mi.csr_re ? csr_rvalue : mi.result); end
            end
            checks++; if ({ws_allowin, retire_cnt} !== {1'b1, mcnt}) begin errors++; $display("FAIL rnd_cnt[%0d] got %b/%h exp 1/%h", n, ws_allowin, retire_cnt, mcnt); end
            if (ok) mcnt++;
            if (trap || eret) mv = 1'b0;
            else begin
                mv = v;
                if (v) mi = ni;
            end
            tick();
        end
        ms_to_ws_valid = 1'b0;
        has_int = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        ms_to_ws_valid = 1'b0;
        ms_to_ws_bus = '0;
        has_int = 1'b0;
        csr_rvalue = '0;
        ex_entry = '0;
        ertn_entry = '0;
        exp_cnt = '0;
        test_reset();
        test_alu();
        test_csrrd();
        test_exception();
        test_interrupt();
        test_ertn();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
